pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register with a valid/ready handshake on both sides.
- Successor to the fixed-width stall/flush stage registers: the same block serves IF/ID, ID/EX, EX/MEM and MEM/WB.
- Optional 2-entry skid buffer gives full throughput with a registered in_ready.
- Adds flush, an occupancy report and a saturating back-pressure counter for performance analysis.

Parameters:
- DATA_W, 65: payload width (e.g. interrupt + pc_plus_4 + instr).
- RESET_VAL, 0: value loaded into all payload registers on reset and on flush.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discard all held entries this cycle.
- clr_stats  in  1  synchronous clear of stall_cnt.
- in_valid  in  1  upstream has payload.
- in_ready  out  1  stage can accept payload.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds valid payload.
- out_ready  in  1  downstream accepts payload.
- out_data  out  DATA_W  payload at head of stage.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Handshake:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload transfers only on a fire.
  - in_valid/in_data may change freely while in_ready=0.
  - out_valid, once high, stays high with out_data stable until out_fire or flush.
- Storage: main register drives out_data; skid register exists only when SKID=1.
- State machine (SKID=1): EMPTY, ONE, TWO.
  - out_valid = (state != EMPTY).
  - occupancy = 0 / 1 / 2 respectively.
- Transitions (SKID=1):
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data.
  - ONE: in_fire & !out_fire -> TWO, skid <= in_data.
  - ONE: !in_fire & out_fire -> EMPTY.
  - TWO: out_fire -> ONE, main <= skid (in_fire is impossible in TWO).
  - Any state with no fire: hold.
- in_ready (SKID=1) is a flop: next value = (next_state != TWO). It therefore depends on no input combinationally.
- SKID=0:
  - States EMPTY and ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - EMPTY/ONE with in_fire -> ONE, main <= in_data; ONE with out_fire & !in_fire -> EMPTY.
- Latency: 1 cycle from in_fire to out_valid. Throughput: 1 transfer/cycle in steady state for both SKID values.
- Flush (priority over all handshakes except reset):
  - State <= EMPTY; main and skid <= RESET_VAL.
  - An in_fire in the flush cycle is discarded.
  - in_ready (SKID=1) is 1 in the following cycle.
  - stall_cnt is unaffected.
- Reset (rst_n=0 at a clock edge, highest priority):
  - State EMPTY, out_valid=0, out_data=RESET_VAL, skid=RESET_VAL, occupancy=0, stall_cnt=0.
  - in_ready=0 (SKID=1): rises to 1 on the first edge with rst_n=1.
  - Reset mid-transfer drops all held entries; no partial state survives.
- Idle output: when EMPTY, out_data holds the last payload (RESET_VAL after reset or flush). Consumers must qualify with out_valid.
- stall_cnt:
  - +1 per cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - clr_stats forces 0, with priority over increment.
- Simultaneous flush & clr_stats: both take effect.

Test Plan:
- Reset then stream: rst_n low 2 cycles, then in_valid=1 with data 1,2,3,4 and out_ready=1 -> in_ready=0 during reset, 1 one cycle after release; out_data 1,2,3,4 on consecutive cycles, 1 cycle after each accept; occupancy stays 1; stall_cnt=0.
- Back-pressure (SKID=1): out_ready=0 while feeding 0xA, 0xB -> occupancy 2, in_ready=0, out_data=0xA held. Then out_ready=1 -> 0xA, then 0xB out, no loss or duplicate; stall_cnt equals the number of stalled cycles.
- Flush with full buffer plus concurrent input: occupancy=2, flush=1, in_valid=1 data 0xC -> next cycle out_valid=0, out_data=RESET_VAL, occupancy=0, 0xC never appears at output.
- SKID=0 combinational ready: out_valid=1, out_ready toggling 1,0,1 -> in_ready follows 1,0,1 in the same cycle; accepted data emerges in order.
- Counter saturation (CNT_W=4): out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds. clr_stats=1 -> 0 next cycle; flush leaves the count unchanged.
- Random traffic: random in_valid, out_ready and flush vs a scoreboard model -> output sequence equals accepted inputs minus flushed entries, in order.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshakes on both sides, optional
// two-entry skid buffer, flush, occupancy report and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int unsigned          DATA_W    = 65,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0,
  parameter int unsigned          SKID      = 1,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_d, skid_val;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_val;
    if (flush) begin
      state_d = StEmpty;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          // Without a skid entry, in_ready implies out_ready while holding one entry.
          if (in_fire && (out_fire || SKID == 0)) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = StTwo;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_val;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    occupancy = 2'd0;
    unique case (state_q)
      StOne:   occupancy = 2'd1;
      StTwo:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_stats) begin
      cnt_d = '0;
    end else if (out_valid && !out_ready && cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      cnt_q   <= cnt_d;
    end
  end

  if (SKID != 0) begin : g_skid
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;

    // Registered ready: looks only at the next state, never at the current inputs.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        skid_q     <= RESET_VAL;
        in_ready_q <= 1'b0;
      end else begin
        skid_q     <= skid_d;
        in_ready_q <= (state_d != StTwo);
      end
    end

    assign skid_val = skid_q;
    assign in_ready = in_ready_q;
  end else begin : g_no_skid
    assign skid_val = RESET_VAL;
    assign in_ready = ~out_valid | out_ready;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table on the skid variant,
// hand-written corner sequences, and random traffic against per-instance scoreboards.
module tb_pipe_stage_reg;

  localparam logic [15:0] RV = 16'h00EE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        clr_stats = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [15:0] out_data1, out_data0;
  logic [1:0]  occ1, occ0;
  logic [3:0]  sc1, sc0;

  int checks = 0;
  int errors = 0;

  logic [15:0] q1[$];
  logic [15:0] q0[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(16), .RESET_VAL(RV), .SKID(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1), .stall_cnt(sc1)
  );

  pipe_stage_reg #(.DATA_W(16), .RESET_VAL(RV), .SKID(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0), .stall_cnt(sc0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: accepted payloads queued, popped and compared on each output fire.
  always @(posedge clk) begin
    if (rst_n !== 1'b1 || flush) begin
      q1.delete();
      q0.delete();
    end else begin
      chk("sb1 occupancy", {30'd0, occ1}, q1.size());
      chk("sb0 occupancy", {30'd0, occ0}, q0.size());
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("sb1 unexpected output", {16'd0, out_data1}, 32'hFFFF_FFFF);
        else chk("sb1 data", {16'd0, out_data1}, {16'd0, q1.pop_front()});
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) chk("sb0 unexpected output", {16'd0, out_data0}, 32'hFFFF_FFFF);
        else chk("sb0 data", {16'd0, out_data0}, {16'd0, q0.pop_front()});
      end
      if (in_valid && in_ready1) q1.push_back(in_data);
      if (in_valid && in_ready0) q0.push_back(in_data);
    end
  end

  typedef struct {
    logic        rst_n, flush, clr, iv;
    logic [15:0] d;
    logic        ordy;
    logic        e_ir, e_ov;
    logic [15:0] e_od;
    logic [1:0]  e_occ;
    logic [3:0]  e_sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic c, input logic iv,
                     input logic [15:0] d, input logic o, input logic eir, input logic eov,
                     input logic [15:0] eod, input logic [1:0] eocc, input logic [3:0] esc);
    vec_t v;
    v.rst_n = r; v.flush = f; v.clr = c; v.iv = iv; v.d = d; v.ordy = o;
    v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_occ = eocc; v.e_sc = esc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic c, input logic iv,
                       input logic [15:0] d, input logic o);
    @(negedge clk);
    rst_n = r; flush = f; clr_stats = c; in_valid = iv; in_data = d; out_ready = o;
  endtask

  task automatic step(input logic r, input logic f, input logic c, input logic iv,
                      input logic [15:0] d, input logic o);
    drive(r, f, c, iv, d, o);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_od[3];
  logic        ord[3];

  initial begin
    //  rst f  c  iv data    or   ir ov out_data occ sc
    add(0, 0, 0, 0, 16'h00, 0,   0, 0, RV,    0, 0);
    add(0, 0, 0, 1, 16'h01, 1,   0, 0, RV,    0, 0);
    add(1, 0, 0, 1, 16'h01, 1,   1, 0, RV,    0, 0);
    add(1, 0, 0, 1, 16'h01, 1,   1, 1, 16'h01, 1, 0);
    add(1, 0, 0, 1, 16'h02, 1,   1, 1, 16'h02, 1, 0);
    add(1, 0, 0, 1, 16'h03, 1,   1, 1, 16'h03, 1, 0);
    add(1, 0, 0, 1, 16'h04, 1,   1, 1, 16'h04, 1, 0);
    add(1, 0, 0, 0, 16'h00, 1,   1, 0, 16'h04, 0, 0);
    add(1, 0, 0, 1, 16'h0A, 0,   1, 1, 16'h0A, 1, 0);
    add(1, 0, 0, 1, 16'h0B, 0,   0, 1, 16'h0A, 2, 1);
    add(1, 0, 0, 1, 16'h77, 0,   0, 1, 16'h0A, 2, 2);
    add(1, 0, 0, 0, 16'h00, 1,   1, 1, 16'h0B, 1, 2);
    add(1, 0, 0, 0, 16'h00, 1,   1, 0, 16'h0B, 0, 2);
    add(1, 0, 0, 1, 16'h11, 0,   1, 1, 16'h11, 1, 2);
    add(1, 0, 0, 1, 16'h22, 0,   0, 1, 16'h11, 2, 3);
    add(1, 1, 0, 1, 16'h0C, 0,   1, 0, RV,    0, 4);
    add(1, 1, 0, 1, 16'h0C, 1,   1, 0, RV,    0, 4);
    add(1, 0, 0, 0, 16'h00, 1,   1, 0, RV,    0, 4);
    add(1, 0, 0, 1, 16'h33, 0,   1, 1, 16'h33, 1, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].flush, vecs[i].clr, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk($sformatf("row%0d in_ready", i), {31'd0, in_ready1}, {31'd0, vecs[i].e_ir});
      chk($sformatf("row%0d out_valid", i), {31'd0, out_valid1}, {31'd0, vecs[i].e_ov});
      chk($sformatf("row%0d out_data", i), {16'd0, out_data1}, {16'd0, vecs[i].e_od});
      chk($sformatf("row%0d occupancy", i), {30'd0, occ1}, {30'd0, vecs[i].e_occ});
      chk($sformatf("row%0d stall_cnt", i), {28'd0, sc1}, {28'd0, vecs[i].e_sc});
    end

    // Stall counter saturation, clear, and flush interaction.
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 16'h00, 0);
    chk("sat stall_cnt", {28'd0, sc1}, 32'd15);
    chk("sat out_data held", {16'd0, out_data1}, 32'h33);
    chk("sat out_valid held", {31'd0, out_valid1}, 32'd1);
    step(1, 0, 1, 0, 16'h00, 0);
    chk("clr stall_cnt", {28'd0, sc1}, 32'd0);
    step(1, 0, 0, 0, 16'h00, 0);
    chk("count after clr", {28'd0, sc1}, 32'd1);
    step(1, 1, 0, 0, 16'h00, 1);
    chk("flush keeps stall_cnt", {28'd0, sc1}, 32'd1);
    chk("flush out_data", {16'd0, out_data1}, {16'd0, RV});
    step(1, 0, 0, 1, 16'h44, 0);
    step(1, 1, 1, 0, 16'h00, 0);
    chk("flush+clr stall_cnt", {28'd0, sc1}, 32'd0);
    chk("flush+clr occupancy", {30'd0, occ1}, 32'd0);

    // Reset with a full skid buffer drops everything.
    step(1, 0, 0, 1, 16'h45, 0);
    step(1, 0, 0, 1, 16'h46, 0);
    chk("pre-reset occupancy", {30'd0, occ1}, 32'd2);
    step(0, 0, 0, 1, 16'h47, 0);
    chk("mid reset occupancy", {30'd0, occ1}, 32'd0);
    chk("mid reset out_valid", {31'd0, out_valid1}, 32'd0);
    chk("mid reset out_data", {16'd0, out_data1}, {16'd0, RV});
    chk("mid reset in_ready", {31'd0, in_ready1}, 32'd0);
    step(1, 0, 0, 0, 16'h00, 0);
    chk("post reset in_ready", {31'd0, in_ready1}, 32'd1);

    // Combinational ready on the single-entry variant.
    step(1, 0, 0, 1, 16'h50, 1);
    chk("skid0 first out_data", {16'd0, out_data0}, 32'h50);
    ord[0] = 1'b1; ord[1] = 1'b0; ord[2] = 1'b1;
    exp_od[0] = 16'h51; exp_od[1] = 16'h51; exp_od[2] = 16'h53;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 16'h51 + 16'(i), ord[i]);
      #1;
      chk($sformatf("skid0 in_ready %0d", i), {31'd0, in_ready0}, {31'd0, ord[i]});
      chk($sformatf("skid0 out_valid %0d", i), {31'd0, out_valid0}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("skid0 out_data %0d", i), {16'd0, out_data0}, {16'd0, exp_od[i]});
    end

    // Random traffic; the scoreboards check ordering and occupancy every cycle.
    for (int i = 0; i < 400; i++) begin
      step(1, ($urandom_range(15) == 0), 1'b0, 1'($urandom_range(1)),
           16'($urandom), 1'($urandom_range(1)));
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'h00, 1);
    chk("drain occupancy skid", {30'd0, occ1}, 32'd0);
    chk("drain occupancy single", {30'd0, occ0}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
